if_id_fetch_ctrl: RTL
=====================

Name: if_id_fetch_ctrl

Overview:
- Consumer side of the instruction-fetch interface; sits between the fetch stage and decode.
- Drives the fetch stage's PC_write, PC_sel, jump_sel, branch_address and jump_address.
- Consumes instruc and PC_current from the fetch stage. The instruction memory is synchronous, so each word arrives one cycle after its address.
- Pairs each word with its fetch address, drops duplicate and wrong-path words, decodes J/JAL early, absorbs decode stalls with a one-entry skid buffer, and holds the IF/ID pipeline register.

Parameters:
- ADDR_W, 10, PC / instruction-address width.
- DATA_W, 32, instruction width.
- J_OP, 6'b000010, opcode of J.
- JAL_OP, 6'b000011, opcode of JAL.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instruc  in  DATA_W  instruction-memory output: word at the address sampled on the previous edge.
- PC_current  in  ADDR_W  current PC value of the fetch stage.
- stall  in  1  decode hazard: hold IF/ID.
- branch_taken  in  1  branch resolved taken this cycle.
- branch_target  in  ADDR_W  target of the taken branch.
- PC_write  out  1  PC update enable to the fetch stage.
- PC_sel  out  1  select branch_address.
- jump_sel  out  1  select jump_address.
- branch_address  out  ADDR_W  equals branch_target.
- jump_address  out  ADDR_W  equals instruc_src[9:0] (zero-extended if ADDR_W>10).
- instruc_ID  out  DATA_W  IF/ID instruction.
- PC_ID  out  ADDR_W  fetch address of instruc_ID.
- valid_ID  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, reset_n=0): valid_ID=0, instruc_ID=0 (NOP), PC_ID=0, skid empty, tag_q=0, new_q=0, squash_q=0.
  - Combinational outputs during reset: PC_write=1, PC_sel=0, jump_sel=0.
  - Reset mid-operation discards IF/ID, the skid entry and the squash state.
- Every edge:
  - tag_q<=PC_current (the address the memory samples).
  - new_q<=PC_write. An arrival is new only if the PC advanced on the edge before the memory sampled it; otherwise it is a duplicate re-read.
- Arrival valid: arr_v = new_q & ~squash_q; the arrival is {instruc, tag_q}.
- Source selection: skid if skid valid, else the arrival. src_v, instruc_src and pc_src are the selected source's valid, word and address.
- load = ~stall | branch_taken.
- Priority is branch, then stall, then jump.
- Branch (branch_taken=1):
  - PC_sel=1, jump_sel=0, PC_write=1.
  - IF/ID valid_ID<=0; skid cleared; squash_q<=1, dropping the one wrong-path arrival.
  - Overrides stall.
- Stall (stall=1, no branch):
  - PC_write=0; IF/ID holds.
  - If arr_v and skid empty, the skid captures the arrival.
  - At most one new arrival can occur per stall, so the skid never overflows. A second arr_v with skid full is a design error; the bench asserts it never happens.
- Normal load (load=1, no branch):
  - IF/ID<={instruc_src, pc_src}, valid_ID<=src_v.
  - If the skid was the source, the skid clears.
  - If src_v and instruc_src[31:26] is J_OP or JAL_OP: jump_sel=1, PC_write=1, squash_q<=1.
  - Otherwise jump_sel=0, PC_write=1, squash_q<=0.
- squash_q clears after one consumed arrival window (one cycle) unless set again.
- Sel encoding to the fetch mux: {PC_sel,jump_sel} = 00 for PC+1, 01 for jump, 10 for branch. 11 is never driven.
- Latency: a word addressed on edge k reaches IF/ID on edge k+1 if not stalled. Jump redirect costs one bubble; branch costs the bubble plus the flushed IF/ID entry.
- Wrap-around: addresses are unsigned mod 2^ADDR_W; no special handling.
- Simultaneous jump in IF source and stall: jump not taken (jump_sel=0); re-evaluated when the word loads.

Test Plan:
- Reset then straight-line code (mem[n]=n+0x100): after the first valid, valid_ID=1 every cycle; PC_ID runs 0,1,2,…; instruc_ID=0x100+PC_ID.
- J at addr 3 with target 0x20: jump_sel=1 for one cycle. Addr 4 is never valid in IF/ID (one bubble, valid_ID=0). The next valid is PC_ID=0x20.
- stall held 3 cycles after PC_ID=5: PC_write=0 for 3 cycles, IF/ID holds 5, skid holds addr 6. After release, IF/ID loads 6 then 7, with no duplicate and no gap beyond the stall.
- branch_taken with branch_target=0x40 while stall=1: PC_sel=1, PC_write=1, valid_ID=0 next cycle, skid emptied. The next valid is PC_ID=0x40.
- Branch and a J in the IF source in the same cycle: PC_sel=1, jump_sel=0; the next valid is branch_target.
- reset_n pulsed low mid-stall with the skid full: outputs return to reset values immediately. After release, the first valid arrives 2 cycles later with the fetch PC.

Source files
------------

// File: rtl/if_id_fetch_ctrl.sv
// IF/ID fetch controller: pairs synchronous-memory words with their fetch address,
// drops duplicate and wrong-path words, decodes J/JAL early and holds the IF/ID register.
module if_id_fetch_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter logic [5:0]  J_OP   = 6'b000010,
  parameter logic [5:0]  JAL_OP = 6'b000011
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] instruc,
  input  logic [ADDR_W-1:0] PC_current,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              PC_write,
  output logic              PC_sel,
  output logic              jump_sel,
  output logic [ADDR_W-1:0] branch_address,
  output logic [ADDR_W-1:0] jump_address,
  output logic [DATA_W-1:0] instruc_ID,
  output logic [ADDR_W-1:0] PC_ID,
  output logic              valid_ID
);

  logic [ADDR_W-1:0] tag_r;
  logic              new_r;
  logic              squash_r;
  logic              skid_v_r;
  logic [DATA_W-1:0] skid_instr_r;
  logic [ADDR_W-1:0] skid_pc_r;

  logic              arr_v_s;
  logic              src_v_s;
  logic [DATA_W-1:0] instr_src_s;
  logic [ADDR_W-1:0] pc_src_s;
  logic              is_jump_s;

  // A word is real only if the PC moved past its address on the sampling edge
  // (otherwise it will be read again) and it is not on a squashed path.
  assign arr_v_s = new_r & ~squash_r;

  // Select the IF source: a parked skid entry is older than the live arrival.
  always_comb begin
    if (skid_v_r) begin
      src_v_s     = 1'b1;
      instr_src_s = skid_instr_r;
      pc_src_s    = skid_pc_r;
    end else begin
      src_v_s     = arr_v_s;
      instr_src_s = instruc;
      pc_src_s    = tag_r;
    end
  end

  assign is_jump_s = src_v_s &&
                     ((instr_src_s[DATA_W-1 -: 6] == J_OP) ||
                      (instr_src_s[DATA_W-1 -: 6] == JAL_OP));

  assign branch_address = branch_target;
  assign jump_address   = ADDR_W'(instr_src_s[9:0]);

  // Fetch-mux control; branch beats stall, stall beats jump.
  always_comb begin
    PC_write = 1'b1;
    PC_sel   = 1'b0;
    jump_sel = 1'b0;
    if (!reset_n) begin
      PC_write = 1'b1;
      PC_sel   = 1'b0;
      jump_sel = 1'b0;
    end else if (branch_taken) begin
      PC_write = 1'b1;
      PC_sel   = 1'b1;
      jump_sel = 1'b0;
    end else if (stall) begin
      PC_write = 1'b0;
      PC_sel   = 1'b0;
      jump_sel = 1'b0;
    end else begin
      PC_write = 1'b1;
      PC_sel   = 1'b0;
      jump_sel = is_jump_s;
    end
  end

  // Arrival tagging, squash window, skid buffer and IF/ID register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_r        <= {ADDR_W{1'b0}};
      new_r        <= 1'b0;
      squash_r     <= 1'b0;
      skid_v_r     <= 1'b0;
      skid_instr_r <= {DATA_W{1'b0}};
      skid_pc_r    <= {ADDR_W{1'b0}};
      valid_ID     <= 1'b0;
      instruc_ID   <= {DATA_W{1'b0}};
      PC_ID        <= {ADDR_W{1'b0}};
    end else begin
      tag_r <= PC_current;
      new_r <= PC_write;
      if (branch_taken) begin
        valid_ID <= 1'b0;
        skid_v_r <= 1'b0;
        squash_r <= 1'b1;
      end else if (stall) begin
        squash_r <= 1'b0;
        if (arr_v_s && !skid_v_r) begin
          skid_v_r     <= 1'b1;
          skid_instr_r <= instruc;
          skid_pc_r    <= tag_r;
        end else begin
          skid_v_r <= skid_v_r;
        end
      end else begin
        instruc_ID <= instr_src_s;
        PC_ID      <= pc_src_s;
        valid_ID   <= src_v_s;
        skid_v_r   <= 1'b0;
        squash_r   <= is_jump_s;
      end
    end
  end

endmodule
